boxcar_ctrl: RTL
================

# boxcar_ctrl

Sequencing controller for the `boxcar` moving-sum filter. It turns a valid/ready sample stream into `ce` pulses for the filter and reprograms the averaging length on request by pulsing the filter reset. It suppresses outputs until the window and the filter pipeline have filled, then presents the filter result as a valid/ready output stream. It sits between the ADC/sample source and downstream DSP, with the filter instance alongside it.

## Interface
- `IW`, 16: sample width; must match the filter's `IW`.
- `LGMEM`, 6: log2 of the maximum window; must match the filter's `LGMEM`.
- `OW`, IW+LGMEM: filter result width.
- `LATENCY`, 4: number of filter `ce` stages from sample input to result register.
- `INIT_NAVG`, 16: window length loaded at reset. Width is LGMEM bits; 0 encodes 2^LGMEM.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `s_valid`, in, 1: input sample valid.
- `s_ready`, out, 1: input sample ready.
- `s_data`, in, IW: signed input sample.
- `cfg_valid`, in, 1: new window-length request.
- `cfg_ready`, out, 1: request accepted when `cfg_valid & cfg_ready`.
- `cfg_navg`, in, LGMEM: requested window length.
- `f_rst`, out, 1: synchronous reset to the filter.
- `f_ce`, out, 1: filter clock enable.
- `f_navg`, out, LGMEM: filter `i_navg`.
- `f_sample`, out, IW: filter `i_sample`; equals `s_data` combinationally.
- `f_result`, in, OW: filter `o_result`.
- `m_valid`, out, 1: output valid.
- `m_ready`, in, 1: output ready.
- `m_data`, out, OW: equals `f_result` combinationally.
- `settled`, out, 1: high while in RUN.

## Operation
- State machine: FLUSH -> FILL -> RUN. A config accept in FILL or RUN returns to FLUSH.
- FLUSH, always exactly 1 cycle:
  - `f_rst`=1, `f_ce`=0, `s_ready`=0, `cfg_ready`=0.
  - Fill counter cleared; `m_valid` cleared.
  - Next state is FILL.
- FILL:
  - `s_ready`=1; `f_ce` = `s_valid & s_ready`.
  - Counter (LGMEM+2 bits) increments on each `f_ce`.
  - SETTLE = W + LATENCY - 1, where W = `f_navg`, or 2^LGMEM when `f_navg`=0.
  - The `f_ce` that brings the count to SETTLE moves the state to RUN and sets `m_valid` on the next cycle.
- RUN:
  - `s_ready` = `!m_valid | m_ready`.
  - Each `f_ce` sets `m_valid` on the next cycle.
  - `m_valid` clears when `m_ready` is high and there is no `f_ce` in the same cycle.
- Config:
  - `cfg_ready`=1 in FILL and RUN.
  - On accept: `f_navg` <= `cfg_navg` and the next state is FLUSH.
  - In the accept cycle, `s_ready` is forced to 0, so config has priority over a sample.
  - An unconsumed output is discarded.
- Output mapping: after the n-th `f_ce` following FLUSH, `f_result` is the sum of samples n-LATENCY+1-W+1 … n-LATENCY+1 (1-based). Any unread value is dropped.
- Width rules:
  - The counter saturates at SETTLE and does not wrap.
  - `f_navg` holds its value between config accepts.

## Timing
- Reset (asynchronous on `rst_n` low):
  - State is FLUSH and `f_rst`=1.
  - `f_ce`, `s_ready`, `cfg_ready`, `m_valid`, `settled` are 0.
  - `f_navg` = INIT_NAVG.
  - The counter is 0.
- After `rst_n` deasserts: 1 FLUSH cycle, then FILL.
- Latency from sample accept to `m_valid` in RUN: 1 cycle.
- Sustained throughput: 1 sample/cycle while `m_ready`=1.
- Backpressure: while `m_valid & !m_ready`, there is no `f_ce`, so `f_result` and `m_data` stay stable.
- Config accept to first `s_ready` in FILL: 2 cycles (accept cycle, FLUSH, then FILL).
- `cfg_valid` in FLUSH waits; it is accepted on the first FILL cycle.
- `rst_n` asserted mid-RUN: outputs go to their reset values immediately (asynchronous). `f_navg` reverts to INIT_NAVG.

## Test plan
- Reset, INIT_NAVG=4, constant `s_data`=100, `m_ready`=1:
  - No `m_valid` for the first 6 accepts.
  - `m_valid`=1 one cycle after the 7th accept, with `m_data`=400.
  - `m_data`=400 every cycle thereafter.
- Reconfigure to 8 mid-RUN, constant 10:
  - `cfg_ready` handshake completes.
  - `f_rst` pulses for 1 cycle; `m_valid` drops.
  - The first output comes after 11 accepts, with `m_data`=80.
- Backpressure:
  - Hold `m_ready`=0 for 5 cycles in RUN with `s_valid`=1.
  - `s_ready`=0, `f_ce`=0, and `m_data` is unchanged for the whole hold.
  - Release: exactly one output per accepted sample, none lost or duplicated.
- `cfg_navg`=0, LGMEM=6, constant 1:
  - The first output comes after 67 accepts, with `m_data`=64.
- Same-cycle `cfg_valid` and `s_valid`:
  - The sample is not accepted (`s_ready`=0) and the config is taken.
  - The sample is accepted later, in FILL.
- `rst_n` pulsed low mid-RUN (asynchronous, between edges):
  - `m_valid` and `s_ready` go to 0 immediately.
  - `f_navg` returns to INIT_NAVG.
  - Fill restarts; the first output comes after 7 accepts.

Source files
------------

// File: rtl/boxcar_ctrl.sv
// ---------------------------------------------------------------------------
// boxcar_ctrl
//
// Sequencing controller for the boxcar moving-sum filter. It converts a
// valid/ready sample stream into filter clock enables. When a new averaging
// length is requested, it pulses the filter reset. It holds the output stream
// invalid until the window and the filter pipeline have filled, then presents
// the filter result as a valid/ready stream.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_valid/s_ready/s_data     input sample stream
//   cfg_valid/cfg_ready/cfg_navg   window-length request (0 means 2^LGMEM)
//   f_rst, f_ce, f_navg, f_sample, f_result   filter-side connections
//   m_valid/m_ready/m_data     filtered output stream
//   settled                    high while in RUN
//
// State table
//   state | meaning
//   FLUSH | one cycle: filter held in reset, fill counter and output cleared
//   FILL  | accepting samples until window plus pipeline depth is reached
//   RUN   | steady state, every accepted sample yields one output
// ---------------------------------------------------------------------------
module boxcar_ctrl #(
    parameter int               IW        = 16,
    parameter int               LGMEM     = 6,
    parameter int               OW        = IW + LGMEM,
    parameter int               LATENCY   = 4,
    parameter logic [LGMEM-1:0] INIT_NAVG = LGMEM'(16)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IW-1:0]    s_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [LGMEM-1:0] cfg_navg,
    output logic             f_rst,
    output logic             f_ce,
    output logic [LGMEM-1:0] f_navg,
    output logic [IW-1:0]    f_sample,
    input  logic [OW-1:0]    f_result,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OW-1:0]    m_data,
    output logic             settled
);

    localparam int CW = LGMEM + 2;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [CW-1:0]   win;
    logic [CW-1:0]   settle;
    logic            cfg_accept;
    logic            s_ready_c;

    assign f_sample = s_data;
    assign m_data   = f_result;

    // A zero window length encodes the full memory depth.
    assign win     = (f_navg == '0) ? CW'(1 << LGMEM) : {2'b00, f_navg};
    assign settle  = win + CW'(LATENCY - 1);
    assign cnt_inc = cnt + CW'(1);

    assign cfg_accept = cfg_valid & cfg_ready;

    // A config accept blocks the sample in the same cycle, so a sample can
    // never be attributed to the window that is about to be discarded.
    always_comb begin
        s_ready_c = 1'b0;
        case (state)
            FLUSH:   s_ready_c = 1'b0;
            FILL:    s_ready_c = ~cfg_accept;
            RUN:     s_ready_c = (~m_valid | m_ready) & ~cfg_accept;
            default: s_ready_c = 1'b0;
        endcase
    end

    assign s_ready = s_ready_c;
    assign f_ce    = s_valid & s_ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FLUSH;
            f_rst     <= 1'b1;
            cfg_ready <= 1'b0;
            settled   <= 1'b0;
            m_valid   <= 1'b0;
            cnt       <= '0;
            f_navg    <= INIT_NAVG;
        end else begin
            case (state)
                FLUSH: begin
                    state     <= FILL;
                    f_rst     <= 1'b0;
                    cfg_ready <= 1'b1;
                    settled   <= 1'b0;
                    m_valid   <= 1'b0;
                    cnt       <= '0;
                end

                FILL: begin
                    if (cfg_accept) begin
                        state     <= FLUSH;
                        f_rst     <= 1'b1;
                        cfg_ready <= 1'b0;
                        settled   <= 1'b0;
                        m_valid   <= 1'b0;
                        f_navg    <= cfg_navg;
                    end else if (f_ce) begin
                        if (cnt_inc >= settle) begin
                            cnt     <= settle;
                            state   <= RUN;
                            settled <= 1'b1;
                            m_valid <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end

                RUN: begin
                    if (cfg_accept) begin
                        state     <= FLUSH;
                        f_rst     <= 1'b1;
                        cfg_ready <= 1'b0;
                        settled   <= 1'b0;
                        m_valid   <= 1'b0;
                        f_navg    <= cfg_navg;
                    end else if (f_ce) begin
                        m_valid <= 1'b1;
                        // Counter stays pinned at the settle point.
                        if (cnt < settle) begin
                            cnt <= cnt_inc;
                        end
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                    end
                end

                default: begin
                    state     <= FLUSH;
                    f_rst     <= 1'b1;
                    cfg_ready <= 1'b0;
                    settled   <= 1'b0;
                    m_valid   <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule
